// File: rtl/pio_ep_reg_bank.sv
// PIO endpoint register bank: per-channel shadow address registers, committed to active outputs on demand.
// Optional build macro PIO_REGS_WRCNT_EN adds a saturating per-channel shadow-write counter at offset 5.
module pio_ep_reg_bank #(
   parameter int          NCH          = 2,
   parameter int          TCQ          = 1,
   parameter logic [31:0] IF_V4_BASE   = 32'h0A0015C7,
   parameter logic [47:0] IF_MAC_BASE  = 48'h003776000001,
   parameter logic [31:0] DEST_V4_RST  = 32'h0A0015FF,
   parameter logic [47:0] DEST_MAC_RST = 48'hFFFFFFFFFFFF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [13:0]       rd_addr,
   output logic [31:0]       rd_data,
   input  logic [13:0]       wr_addr,
   input  logic [7:0]        wr_be,
   input  logic [31:0]       wr_data,
   input  logic              wr_en,
   output logic              wr_busy,
   output logic [NCH*32-1:0] if_v4addr,
   output logic [NCH*32-1:0] dest_v4addr,
   output logic [NCH*48-1:0] if_macaddr,
   output logic [NCH*48-1:0] dest_macaddr
);

   // TCQ only matters to behavioural models; this RTL carries no delays.
   if (NCH < 1 || NCH > 8) begin : g_bad_nch
      $error("pio_ep_reg_bank: NCH must be 1..8");
   end
   if (TCQ < 0) begin : g_bad_tcq
      $error("pio_ep_reg_bank: TCQ must be non-negative");
   end

   logic [31:0] sh_if_v4   [NCH];
   logic [31:0] sh_dest_v4 [NCH];
   logic [47:0] sh_if_mac  [NCH];
   logic [47:0] sh_dest_mac[NCH];
   logic [NCH-1:0] dirty;
   logic [7:0]     commit_cnt;
   logic [2:0]     cm_ch;
`ifdef PIO_REGS_WRCNT_EN
   logic [15:0]    wr_cnt [NCH];
`endif

   logic [2:0] wr_ch, wr_off, rd_ch, rd_off;
   logic       wr_bank, rd_bank, wr_chv, wr_acc, wr_used;
   logic [31:0] rd_mux;
   logic        unused_ok;

   assign wr_bank   = (wr_addr[13:12] == 2'b01);
   assign rd_bank   = (rd_addr[13:12] == 2'b01);
   assign wr_ch     = wr_addr[5:3];
   assign wr_off    = wr_addr[2:0];
   assign rd_ch     = rd_addr[5:3];
   assign rd_off    = rd_addr[2:0];
   assign unused_ok = ^{wr_be[7:4], wr_addr[11:6], rd_addr[11:6]};

   // Offsets 3/7 hold only 16 MAC bits in the upper half, so only be[1:0] matter there.
   assign wr_used = (wr_off[1:0] == 2'd3) ? |wr_be[1:0] : |wr_be[3:0];
   assign wr_acc  = wr_en && !wr_busy && wr_bank && wr_chv;

   // be[0] selects the most significant byte.
   function automatic logic [31:0] merge32(input logic [31:0] old, input logic [31:0] d,
                                           input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (be[b]) r[31-8*b -: 8] = d[31-8*b -: 8];
      return r;
   endfunction

   always_comb begin
      wr_chv = 1'b0;
      rd_mux = 32'h0;
      for (int c = 0; c < NCH; c++) begin
         if (wr_ch == 3'(c)) wr_chv = 1'b1;
         if (rd_bank && rd_ch == 3'(c)) begin
            case (rd_off)
               3'd0: rd_mux = sh_if_v4[c];
               3'd1: rd_mux = {commit_cnt, 23'b0, dirty[c]};
               3'd2: rd_mux = sh_if_mac[c][47:16];
               3'd3: rd_mux = {sh_if_mac[c][15:0], 16'h0};
               3'd4: rd_mux = sh_dest_v4[c];
`ifdef PIO_REGS_WRCNT_EN
               3'd5: rd_mux = {16'h0, wr_cnt[c]};
`else
               3'd5: rd_mux = 32'h0;
`endif
               3'd6: rd_mux = sh_dest_mac[c][47:16];
               default: rd_mux = {sh_dest_mac[c][15:0], 16'h0};
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_data    <= 32'h0;
         wr_busy    <= 1'b0;
         commit_cnt <= 8'h0;
         cm_ch      <= 3'd0;
         dirty      <= '0;
         for (int c = 0; c < NCH; c++) begin
            sh_if_v4[c]            <= IF_V4_BASE + 32'(c);
            sh_dest_v4[c]          <= DEST_V4_RST;
            sh_if_mac[c]           <= IF_MAC_BASE + 48'(c);
            sh_dest_mac[c]         <= DEST_MAC_RST;
            if_v4addr[c*32 +: 32]  <= IF_V4_BASE + 32'(c);
            dest_v4addr[c*32 +: 32] <= DEST_V4_RST;
            if_macaddr[c*48 +: 48] <= IF_MAC_BASE + 48'(c);
            dest_macaddr[c*48 +: 48] <= DEST_MAC_RST;
`ifdef PIO_REGS_WRCNT_EN
            wr_cnt[c]              <= 16'h0;
`endif
         end
      end else begin
         rd_data <= rd_mux;
         if (wr_busy) begin
            // Commit cycle: any write presented now is dropped.
            wr_busy    <= 1'b0;
            commit_cnt <= commit_cnt + 8'd1;
            for (int c = 0; c < NCH; c++) begin
               if (cm_ch == 3'(c)) begin
                  if_v4addr[c*32 +: 32]    <= sh_if_v4[c];
                  dest_v4addr[c*32 +: 32]  <= sh_dest_v4[c];
                  if_macaddr[c*48 +: 48]   <= sh_if_mac[c];
                  dest_macaddr[c*48 +: 48] <= sh_dest_mac[c];
                  dirty[c]                 <= 1'b0;
               end
            end
         end else if (wr_acc) begin
            if (wr_off == 3'd1) begin
               if (wr_be[3] && wr_data[0]) begin
                  wr_busy <= 1'b1;
                  cm_ch   <= wr_ch;
               end
            end else if (wr_off != 3'd5 && wr_used) begin
               for (int c = 0; c < NCH; c++) begin
                  if (wr_ch == 3'(c)) begin
                     case (wr_off)
                        3'd0: sh_if_v4[c] <= merge32(sh_if_v4[c], wr_data, wr_be[3:0]);
                        3'd2: sh_if_mac[c][47:16] <= merge32(sh_if_mac[c][47:16], wr_data, wr_be[3:0]);
                        3'd3: sh_if_mac[c][15:0] <=
                                 16'(merge32({sh_if_mac[c][15:0], 16'h0}, wr_data, {2'b00, wr_be[1:0]}) >> 16);
                        3'd4: sh_dest_v4[c] <= merge32(sh_dest_v4[c], wr_data, wr_be[3:0]);
                        3'd6: sh_dest_mac[c][47:16] <= merge32(sh_dest_mac[c][47:16], wr_data, wr_be[3:0]);
                        default: sh_dest_mac[c][15:0] <=
                                 16'(merge32({sh_dest_mac[c][15:0], 16'h0}, wr_data, {2'b00, wr_be[1:0]}) >> 16);
                     endcase
                     dirty[c] <= 1'b1;
`ifdef PIO_REGS_WRCNT_EN
                     if (wr_cnt[c] != 16'hFFFF) wr_cnt[c] <= wr_cnt[c] + 16'd1;
`endif
                  end
               end
            end
         end
      end
   end

endmodule

// File: doc/pio_ep_reg_bank.md
PIO_EP_REG_BANK -- requirements
Module: pio_ep_reg_bank

Interface
REQ-001 SHALL have parameter NCH, default 2, meaning number of interface channels (legal 1..8).
REQ-002 SHALL have parameter TCQ, default 1, meaning simulation clock-to-Q delay in ps.
REQ-003 SHALL have parameter IF_V4_BASE, default 32'h0A0015C7 (10.0.21.199), meaning channel-0 if_v4addr reset value; channel c resets to IF_V4_BASE+c.
REQ-004 SHALL have parameter IF_MAC_BASE, default 48'h003776000001, meaning channel-0 if_macaddr reset value; channel c resets to IF_MAC_BASE+c.
REQ-005 SHALL have parameter DEST_V4_RST, default 32'h0A0015FF, meaning dest_v4addr reset value for all channels.
REQ-006 SHALL have parameter DEST_MAC_RST, default 48'hFFFFFFFFFFFF, meaning dest_macaddr reset value for all channels.
REQ-007 clk  input  1  clock; all logic on rising edge.
REQ-008 rst_n  input  1  reset, synchronous, active-low.
REQ-009 rd_addr  input  14  DW read address.
REQ-010 rd_data  output  32  registered read data.
REQ-011 wr_addr  input  14  DW write address.
REQ-012 wr_be  input  8  byte enables; only [3:0] used.
REQ-013 wr_data  input  32  write data.
REQ-014 wr_en  input  1  write strobe, one DW per cycle.
REQ-015 wr_busy  output  1  high during commit cycle; writes ignored while high.
REQ-016 if_v4addr / dest_v4addr  output  NCH*32  active addresses, channel c at [c*32+:32].
REQ-017 if_macaddr / dest_macaddr  output  NCH*48  active MACs, channel c at [c*48+:48].

Function
REQ-018 SHALL decode bank when addr[13:12]==2'b01; channel=addr[5:3], offset=addr[2:0]; other banks or channel>=NCH: reads return 0, writes ignored.
REQ-019 Offsets SHALL be: 0 if_v4, 1 control/status, 2 if_mac[47:16], 3 {if_mac[15:0],16'h0}, 4 dest_v4, 5 write counter (see Configuration), 6 dest_mac[47:16], 7 {dest_mac[15:0],16'h0}.
REQ-020 Writes to offsets 0,2,3,4,6,7 SHALL update per-channel shadow registers only; wr_be[0]->data[31:24], [1]->[23:16], [2]->[15:8], [3]->[7:0]; offsets 3/7 use wr_be[1:0] only.
REQ-021 Any accepted shadow write with nonzero used byte enables SHALL set channel dirty flag.
REQ-022 Write to offset 1 with wr_be[3]=1 and wr_data[0]=1 at cycle T SHALL raise wr_busy in T+1; at end of T+1 copy that channel's shadow to active outputs, clear dirty, increment 8-bit commit_cnt (wraps 255->0); wr_busy low and new outputs visible from T+2.
REQ-023 Offset 1 read SHALL return {commit_cnt[7:0], 23'b0, dirty}.
REQ-024 Reads of data offsets SHALL return shadow values.
REQ-025 Read latency SHALL be 1 cycle: rd_data at edge after rd_addr presented, read every cycle unconditionally.
REQ-026 Same-cycle read and write of one register SHALL return pre-write value.
REQ-027 wr_en during wr_busy SHALL be dropped with no state change (including counters).
REQ-028 Commit on a non-dirty channel SHALL still copy, increment commit_cnt and assert wr_busy.

Reset
REQ-029 rst_n low at a clock edge SHALL load shadow and active registers with parameter reset values, clear dirty, commit_cnt, write counters, rd_data=0, wr_busy=0.
REQ-030 Reset SHALL override a pending or in-progress commit; no copy occurs.

Configuration
REQ-031 With PIO_REGS_WRCNT_EN defined: per-channel 16-bit counter of accepted shadow writes, saturating at 16'hFFFF, read at offset 5, cleared only by reset; without: offset 5 reads 0, no counter logic.

Verification
REQ-032 Reset, NCH=2 -> if_v4addr ch1=0x0A0015C8, if_macaddr ch1=0x003776000002, rd_data=0, wr_busy=0.
REQ-033 Write 0x0A000101 to addr 0x1000 be=0xF, read 0x1000 -> rd_data 0x0A000101 next cycle; if_v4addr ch0 unchanged; read 0x1001 -> 0x00000001.
REQ-034 Then write 0x1 to 0x1001 be=0x8 -> wr_busy high one cycle; if_v4addr ch0=0x0A000101 two cycles after write; 0x1001 reads 0x01000000.
REQ-035 wr_en to 0x1002 during wr_busy -> shadow unchanged, dirty stays 0.
REQ-036 Write be=0x2 to 0x1003 data 0x00AB0000 -> if_mac shadow ch0 low byte 0xAB, others kept; write to 0x1018 with NCH=2 -> ignored, reads 0.
REQ-037 With PIO_REGS_WRCNT_EN, 3 shadow writes to ch1 -> 0x100D reads 3; without macro reads 0.
